unsigned_divider: RTL
=====================

UNSIGNED_DIVIDER -- requirements
Module: unsigned_divider

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-high reset; the clock SHALL be named clk and the reset rst, listed first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  64  unsigned dividend, e.g. a product from the 32x32 multiplier.
REQ-006 divisor  input  32  unsigned divisor.
REQ-007 quotient  output  32  registered quotient.
REQ-008 remainder  output  32  registered remainder.
REQ-009 busy  output  1  high whenever state is not IDLE.
REQ-010 done  output  1  one-cycle pulse when results are valid.
REQ-011 div_zero  output  1  divisor was zero; held until the next accepted start.
REQ-012 ovf  output  1  quotient does not fit in 32 bits (dividend[63:32] >= divisor, divisor nonzero); held until the next accepted start.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and DONE: IDLE->CALC on start, CALC->DONE after 32 iterations, DONE->IDLE unconditionally.
REQ-014 On the start edge the block SHALL latch dividend and divisor, clear the iteration counter, clear div_zero and ovf, and load the 33-bit partial remainder with dividend[63:32].
REQ-015 Each CALC cycle SHALL shift the partial remainder left by one, inserting the next dividend[31:0] bit MSB-first, then subtract the divisor and set the quotient bit if the result is non-negative, otherwise restore.
REQ-016 done SHALL be high exactly in DONE, i.e. on the 33rd cycle after the start edge (fixed latency 33 without REQ-024).
REQ-017 quotient, remainder, div_zero and ovf SHALL update only on entry to DONE and hold until the next accepted start.
REQ-018 When divisor is zero, the result SHALL be quotient=32'hFFFF_FFFF, remainder=dividend[31:0], div_zero=1, ovf=0.
REQ-019 When ovf is set, the result SHALL be quotient=32'hFFFF_FFFF, remainder=dividend[31:0], div_zero=0.
REQ-020 start asserted while busy SHALL be ignored; inputs changing after the start edge SHALL not affect the result.
REQ-021 Back-to-back operation: start asserted in the cycle after DONE SHALL be accepted in IDLE; there is no input-side buffering.

Reset
REQ-022 rst SHALL force state IDLE and clear quotient, remainder, busy, done, div_zero, ovf, the counter and the partial remainder, immediately and independent of clk.
REQ-023 rst asserted mid-CALC SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL behave as from power-up.

Configuration
REQ-024 With macro DIV_EARLY_TERM_EN defined, divide-by-zero and overflow SHALL bypass CALC: IDLE->DONE directly, done high on the cycle after the start edge (latency 1), results per REQ-018/REQ-019.
REQ-025 Without DIV_EARLY_TERM_EN, every operation SHALL take 32 CALC cycles and latency 33, with special-case results forced on entry to DONE.

Verification
REQ-026 dividend=64'd100, divisor=32'd7, start pulse -> busy high, done at cycle 33, quotient=14, remainder=2, flags 0.
REQ-027 dividend=64'hFFFF_FFFE_0000_0001, divisor=32'hFFFF_FFFF -> quotient=32'hFFFF_FFFF, remainder=0, ovf=0.
REQ-028 dividend=64'h0000_0000_1234_5678, divisor=0 -> div_zero=1, quotient=32'hFFFF_FFFF, remainder=32'h1234_5678; done at cycle 1 with DIV_EARLY_TERM_EN, cycle 33 without.
REQ-029 dividend=64'h0000_0005_0000_0000, divisor=5 -> ovf=1, quotient=32'hFFFF_FFFF, remainder=0.
REQ-030 Second start with new operands at cycle 10 of a running 100/7 -> ignored; result still 14 r 2; no extra done.
REQ-031 rst pulsed at cycle 15 of 100/7 -> all outputs 0 immediately, no done; a fresh start of 100/7 yields 14 r 2 at cycle 33.

Source files
------------

// File: rtl/unsigned_divider.sv
// -----------------------------------------------------------------------------
// unsigned_divider
//   Sequential restoring divider: 64-bit unsigned dividend / 32-bit unsigned
//   divisor -> 32-bit quotient and 32-bit remainder. One quotient bit is
//   produced per clock, so a normal operation takes 32 CALC cycles and done
//   pulses 33 cycles after the start edge.
//
//   Special cases:
//     divisor == 0                   -> quotient = all ones,
//                                       remainder = dividend[31:0], div_zero = 1
//     dividend[63:32] >= divisor     -> quotient = all ones,
//                                       remainder = dividend[31:0], ovf = 1
//
//   Optional feature (macro DIV_EARLY_TERM_EN):
//     When defined, the two special cases skip CALC and go IDLE -> DONE on the
//     start edge, so done pulses one cycle after the start edge. When the
//     macro is undefined, every operation runs the full 32 iterations and the
//     special-case results are forced on entry to DONE.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   asynchronous active-high reset
//   start      in   1   request a division (sampled only in IDLE)
//   dividend   in   64  unsigned dividend
//   divisor    in   32  unsigned divisor
//   quotient   out  32  registered quotient, valid from done until next start
//   remainder  out  32  registered remainder, valid from done until next start
//   busy       out  1   high whenever the FSM is not in IDLE
//   done       out  1   one-cycle pulse when results become valid
//   div_zero   out  1   divisor was zero; held until the next accepted start
//   ovf        out  1   quotient did not fit in 32 bits; held likewise
//
// FSM states
//   state | meaning
//   IDLE  | waiting for start; results of the last operation held
//   CALC  | one shift/subtract/restore iteration per cycle (32 cycles)
//   DONE  | results just loaded, done high for this single cycle
// -----------------------------------------------------------------------------
module unsigned_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q,     state_d;
  logic [4:0]  cnt_q,       cnt_d;
  logic [32:0] prem_q,      prem_d;
  logic [31:0] dvd_lo_q,    dvd_lo_d;
  logic [31:0] dvs_q,       dvs_d;
  logic [31:0] quo_acc_q,   quo_acc_d;
  logic        dz_pend_q,   dz_pend_d;
  logic        ov_pend_q,   ov_pend_d;

  logic [31:0] quotient_q,  quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;
  logic        div_zero_q,  div_zero_d;
  logic        ovf_q,       ovf_d;

  // Classification of the operands presented with start.
  logic        in_dz;
  logic        in_ov;

  // Datapath of one iteration.
  logic        next_bit;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic        trial_ok;
  logic        last_iter;

  assign in_dz = (divisor == 32'd0);
  assign in_ov = !in_dz && (dividend[63:32] >= divisor);

  // Dividend low bits are consumed MSB-first, indexed by the iteration count.
  assign next_bit  = dvd_lo_q[5'd31 - cnt_q];
  assign shifted   = {prem_q[31:0], next_bit};
  // One extra bit so the borrow of the trial subtraction is visible.
  assign trial     = {1'b0, shifted} - {2'b00, dvs_q};
  assign trial_ok  = ~trial[33];
  assign last_iter = (cnt_q == 5'd31);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    dvd_lo_d    = dvd_lo_q;
    dvs_d       = dvs_q;
    quo_acc_d   = quo_acc_q;
    dz_pend_d   = dz_pend_q;
    ov_pend_d   = ov_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_lo_d   = dividend[31:0];
          dvs_d      = divisor;
          cnt_d      = 5'd0;
          prem_d     = {1'b0, dividend[63:32]};
          quo_acc_d  = 32'd0;
          dz_pend_d  = in_dz;
          ov_pend_d  = in_ov;
          div_zero_d = 1'b0;
          ovf_d      = 1'b0;
`ifdef DIV_EARLY_TERM_EN
          if (in_dz || in_ov) begin
            state_d     = DONE;
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = dividend[31:0];
            div_zero_d  = in_dz;
            ovf_d       = in_ov;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end
      end

      CALC: begin
        prem_d    = trial_ok ? trial[32:0] : shifted;
        quo_acc_d = {quo_acc_q[30:0], trial_ok};
        cnt_d     = cnt_q + 5'd1;
        if (last_iter) begin
          state_d = DONE;
          // Special cases still run the iterations; their garbage is
          // replaced by the fixed result here.
          if (dz_pend_q || ov_pend_q) begin
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = dvd_lo_q;
          end else begin
            quotient_d  = {quo_acc_q[30:0], trial_ok};
            remainder_d = trial_ok ? trial[31:0] : shifted[31:0];
          end
          div_zero_d = dz_pend_q;
          ovf_d      = ov_pend_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 5'd0;
      prem_q      <= 33'd0;
      dvd_lo_q    <= 32'd0;
      dvs_q       <= 32'd0;
      quo_acc_q   <= 32'd0;
      dz_pend_q   <= 1'b0;
      ov_pend_q   <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      dvd_lo_q    <= dvd_lo_d;
      dvs_q       <= dvs_d;
      quo_acc_q   <= quo_acc_d;
      dz_pend_q   <= dz_pend_d;
      ov_pend_q   <= ov_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign ovf       = ovf_q;

endmodule
